// File: rtl/alu_uart_pkg.sv
// Shared UART definitions for the ALU result link (tx now, rx later).
// Optional parity feature macro: ALU_TX_PARITY_EN.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  localparam int DEF_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Request/status bundle between the ALU side and the UART transmitter.
// The serial line o_tx rides along so the whole link is one port.
interface alu_result_uart_tx_if #(
  parameter int NB_RES = 9
);

  logic              i_start;
  logic [NB_RES-1:0] i_res;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start,
    output i_res,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_res,
    output o_tx,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT cycles.
// A sync clear holds the count at zero so a frame starts bit-aligned.
module uart_baud_tick
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          term;

  assign term   = (cnt_q == LAST);
  assign o_tick = term && !i_clr;

  // Next count: wrap on terminal count, hold zero while cleared.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clr || term) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Sends an ALU result as two UART frames: low byte then high byte.
// Define ALU_TX_PARITY_EN to append an even-parity bit to each frame.
module alu_result_uart_tx
  import alu_uart_pkg::*;
#(
  parameter int NB_RES       = 9,
  parameter int NB_FRAME     = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input logic                 i_clk,
  input logic                 i_reset,
  alu_result_uart_tx_if.slave bus
);

  localparam int BW = $clog2(NB_FRAME);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_FRAME - 1);

  tx_state_e         state_q;
  logic [NB_RES-1:0] sh_q;
  logic [BW-1:0]     bit_q;
  logic              byte_q;
  logic              par_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (state_q == IDLE),
    .o_tick (tick)
  );

  assign bus.o_tx   = tx_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

  // Frame sequencer; the shift register walks right so the high
  // part lands in the low bits ready for the second frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= UART_IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            sh_q    <= bus.i_res;
            byte_q  <= 1'b0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= sh_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            sh_q  <= sh_q >> 1;
            par_q <= par_q ^ sh_q[0];
            bit_q <= bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef ALU_TX_PARITY_EN
              tx_q    <= par_q ^ sh_q[0];
              state_q <= PARITY;
`else
              tx_q    <= STOP_BIT;
              state_q <= STOP;
`endif
            end else begin
              tx_q <= sh_q[1];
            end
          end
        end
`ifdef ALU_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_q    <= STOP_BIT;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (!byte_q) begin
              byte_q  <= 1'b1;
              par_q   <= 1'b0;
              tx_q    <= START_BIT;
              state_q <= START;
            end else begin
              tx_q    <= UART_IDLE_LVL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= UART_IDLE_LVL;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: mid-bit UART monitor plus frame model.
// Build with ALU_TX_PARITY_EN to cover the parity variant.
module tb_alu_result_uart_tx;

  localparam int C = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LAT = 2 * FB * C + 1;

  typedef struct packed {
    logic       st;
    logic [7:0] d;
    logic       p;
    logic       sp;
  } frame_t;

  logic clk = 1'b0;
  logic i_reset;

  alu_result_uart_tx_if #(.NB_RES(9)) bus ();

  alu_result_uart_tx #(
    .NB_RES      (9),
    .NB_FRAME    (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  // UART receiver model: find the falling edge, then sample mid-bit.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (i_reset === 1'b0 && bus.o_tx === 1'b0) begin
        f = '0;
        repeat (C / 2) @(negedge clk);
        f.st = bus.o_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          f.d[i] = bus.o_tx;
        end
`ifdef ALU_TX_PARITY_EN
        repeat (C) @(negedge clk);
        f.p = bus.o_tx;
`endif
        repeat (C) @(negedge clk);
        f.sp = bus.o_tx;
        rx_q.push_back(f);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [8:0] r);
    exp_q.push_back(r[7:0]);
    exp_q.push_back({7'b0, r[8]});
  endtask

  task automatic send(input logic [8:0] res, input int poke_at);
    int n;
    int busy_bad;
    bit seen;
    n = 0;
    busy_bad = 0;
    seen = 0;
    bus.i_start = 1'b1;
    bus.i_res = res;
    while (!seen && n < LAT + 40) begin
      tick();
      n++;
      bus.i_start = (n == poke_at);
      if (n == poke_at) bus.i_res = 9'h0FF;
      if (n == 1) begin
        n_cmp++;
        if (bus.o_tx !== 1'b0) begin
          n_bad++;
          $display("FAIL start_bit res=%h tx=%b want 0", res, bus.o_tx);
        end
      end
      if (bus.o_done === 1'b1) begin
        seen = 1;
        if (bus.o_busy !== 1'b0) busy_bad++;
      end else if (bus.o_busy !== 1'b1) begin
        busy_bad++;
      end
    end
    n_cmp++;
    if (!seen || n != LAT) begin
      n_bad++;
      $display("FAIL latency res=%h got %0d (seen=%0d) want %0d",
               res, n, seen, LAT);
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_bad++;
      $display("FAIL busy_window res=%h bad_cycles=%0d want 0",
               res, busy_bad);
    end
  endtask

  task automatic check_frames(input string tag);
    int w;
    frame_t f;
    logic [7:0] e;
    w = 0;
    while (rx_q.size() < exp_q.size() && w < 40) begin
      tick();
      w++;
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s frame_count got %0d want %0d",
               tag, rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (f.st !== 1'b0 || f.d !== e || f.sp !== 1'b1) begin
        n_bad++;
        $display("FAIL %s frame got st=%b d=%h sp=%b want st=0 d=%h sp=1",
                 tag, f.st, f.d, f.sp, e);
      end
`ifdef ALU_TX_PARITY_EN
      n_cmp++;
      if (f.p !== ^e) begin
        n_bad++;
        $display("FAIL %s parity d=%h got %b want %b", tag, e, f.p, ^e);
      end
`endif
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    i_reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_res = '0;
    repeat (3) tick();
    i_reset = 1'b0;
    n_cmp++;
    if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vals tx=%b busy=%b done=%b want 1 0 0",
               bus.o_tx, bus.o_busy, bus.o_done);
    end
    repeat (12) begin
      tick();
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL idle_hold bad_cycles=%0d want 0", bad);
    end
    rx_q.delete();
  endtask

  task automatic test_basic();
    expect_res(9'h1A5);
    send(9'h1A5, 0);
    check_frames("basic");
    repeat (3) tick();
  endtask

  task automatic test_ignore_busy();
    expect_res(9'h1A5);
    send(9'h1A5, 10);
    check_frames("ignore");
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    bus.i_start = 1'b1;
    bus.i_res = 9'h1A5;
    tick();
    bus.i_start = 1'b0;
    repeat (11) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    n_cmp++;
    if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid tx=%b busy=%b want 1 0",
               bus.o_tx, bus.o_busy);
    end
    repeat (60) begin
      tick();
      if (bus.o_done !== 1'b0 || bus.o_tx !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet bad_cycles=%0d want 0", bad);
    end
    rx_q.delete();
    expect_res(9'h055);
    send(9'h055, 0);
    check_frames("after_reset");
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    expect_res(9'h13C);
    expect_res(9'h0C3);
    send(9'h13C, 0);
    send(9'h0C3, 0);
    check_frames("b2b");
    repeat (3) tick();
  endtask

`ifdef ALU_TX_PARITY_EN
  task automatic test_parity();
    frame_t f0;
    frame_t f1;
    send(9'h007, 0);
    tick();
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_bad++;
      $display("FAIL parity_frames got %0d want 2", rx_q.size());
    end else begin
      f0 = rx_q[0];
      f1 = rx_q[1];
      n_cmp++;
      if (f0.d !== 8'h07 || f0.p !== 1'b1) begin
        n_bad++;
        $display("FAIL parity_07 got d=%h p=%b want 07 1", f0.d, f0.p);
      end
      n_cmp++;
      if (f1.d !== 8'h00 || f1.p !== 1'b0) begin
        n_bad++;
        $display("FAIL parity_00 got d=%h p=%b want 00 0", f1.d, f1.p);
      end
    end
    rx_q.delete();
    repeat (3) tick();
  endtask
`endif

  task automatic test_random();
    logic [8:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 9'($urandom_range(0, 511));
      expect_res(r);
      send(r, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 70)) : 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) tick();
    end
    check_frames("random");
  endtask

  initial begin
    i_reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_res = '0;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef ALU_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
